spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  - SPI initiator; pairs with spi_slave on the same sclk/mosi/miso/ss bus.
//  - Generates sclk from clk, drives ss and mosi, samples miso.
//  - Shifts one DATA_W-bit frame per start; all four CPOL/CPHA modes.
//  - Front-end for spi_slave bring-up and loopback tests in PS-1/SPI.
// PARAMETERS
//  - DATA_W   8  frame width in bits (>=2)
//  - CLK_DIV  4  clk cycles per sclk half-period (>=1); sclk = clk/(2*CLK_DIV)
// PORTS
//  - clk        in   1       system clock, all logic on posedge
//  - reset      in   1       synchronous, active-low reset
//  - start      in   1       frame request; sampled only in IDLE
//  - datain     in   DATA_W  tx word, latched when start is accepted
//  - cpol       in   1       sclk idle level, latched with start
//  - cpha       in   1       0: sample leading edge; 1: sample trailing edge
//  - miso       in   1       serial data from slave
//  - sclk       out  1       serial clock
//  - mosi       out  1       serial data to slave
//  - ss         out  1       slave select, active-low
//  - dataout    out  DATA_W  last received word, valid when done pulses
//  - busy       out  1       high from start accept until return to IDLE
//  - done       out  1       one-clk pulse at frame end
//  - statemon   out  2       current state encoding (debug)
// BEHAVIOUR
//  - reset==0 at posedge: state=IDLE, ss=1, sclk=cpol input, mosi=0,
//    dataout=0, busy=0, done=0, statemon=2'b00, counters cleared.
//  - Reset mid-frame aborts at once: same values next cycle, no done pulse.
//  - States: IDLE(00) -> SETUP(01) -> XFER(10) -> FINISH(11) -> IDLE.
//  - IDLE: sclk follows cpol input. start==1 latches datain/cpol/cpha;
//    next cycle ss=0, busy=1, state=SETUP.
//  - SETUP: lasts CLK_DIV cycles (ss-to-first-edge). cpha=0: mosi = first
//    data bit during SETUP. cpha=1: mosi driven on first (leading) edge.
//  - XFER: sclk toggles every CLK_DIV clks; exactly 2*DATA_W edges.
//    Leading edge = away from cpol, trailing = back to cpol.
//    cpha=0: sample miso on leading, shift mosi on trailing (not after last).
//    cpha=1: shift mosi on leading, sample miso on trailing.
//  - Bit order MSB first (see CONFIGURATION). Edge counter of
//    $clog2(2*DATA_W)+1 bits; no wrap inside a frame.
//  - After edge 2*DATA_W, sclk == latched cpol; go FINISH.
//  - FINISH: holds CLK_DIV cycles, then ss=1, dataout=rx shift reg, done=1
//    for one clk, busy=0, state=IDLE in the same cycle.
//  - start while busy: ignored, no queueing. start high in the done cycle:
//    ignored; accepted earliest the following cycle (min 1 idle clk).
//  - Changing datain/cpol/cpha while busy: no effect on current frame.
//  - Latency start->done: 1 + CLK_DIV*(2*DATA_W + 2) clks.
//  - dataout holds its value until the next done; mosi holds last bit in IDLE.
// CONFIGURATION
//  - SPI_MASTER_LSB_FIRST_EN defined: tx and rx shift LSB first; dataout
//    bit order matches datain (loopback returns the identical word).
//  - Undefined (default): MSB first on both mosi and miso.
// TESTING
//  - Mode 0, CLK_DIV=4, datain=8'hD1, miso tied to mosi -> 16 sclk edges,
//    mosi sequence 1,1,0,1,0,0,0,1; dataout=8'hD1; done at clk 1+4*18=73.
//  - Mode 3 (cpol=1,cpha=1), datain=8'hC6, miso held at 1 -> sclk idles
//    high, ss low for whole frame, dataout=8'hFF, done pulses once.
//  - start re-asserted at clk 10 of an 8'hA5 frame with datain=8'h3C ->
//    ignored; dataout=8'hA5 (loopback); exactly one done.
//  - reset=0 at clk 20 of a frame -> next clk ss=1, busy=0, statemon=00,
//    no done; new start afterward completes normally.
//  - CLK_DIV=1, start held high continuously, loopback 8'h5A -> back-to-back
//    frames, one idle clk between done and next ss fall; each dataout=8'h5A.
//  - SPI_MASTER_LSB_FIRST_EN defined, datain=8'h01 -> first mosi bit 1,
//    remaining 0; loopback dataout=8'h01.

Source files
------------

// File: rtl/spi_master.sv
// SPI initiator: one DATA_W-bit frame per start, all four CPOL/CPHA modes, sclk = clk/(2*CLK_DIV).
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first on both mosi and miso (default MSB first).
module spi_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] datain,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              ss,
    output logic [DATA_W-1:0] dataout,
    output logic              busy,
    output logic              done,
    output logic [1:0]        statemon
);

    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        XFER   = 2'b10,
        FINISH = 2'b11
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   div_cnt;
    logic [EDGE_W-1:0]  edge_cnt;
    logic [DATA_W-1:0]  tx_sr;
    logic [DATA_W-1:0]  rx_sr;
    logic               cpha_l;

    logic div_end;
    logic leading;
    logic last_edge;

    // Bit-order helpers: tx_sr always holds the bits not yet put on mosi.
    function automatic logic tx_bit(input logic [DATA_W-1:0] w);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return w[0];
`else
        return w[DATA_W-1];
`endif
    endfunction

    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return w >> 1;
`else
        return w << 1;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return {b, w[DATA_W-1:1]};
`else
        return {w[DATA_W-2:0], b};
`endif
    endfunction

    assign div_end   = (div_cnt == CNT_W'(CLK_DIV - 1));
    assign leading   = ~edge_cnt[0];
    assign last_edge = (edge_cnt == EDGE_W'(2 * DATA_W - 1));
    assign statemon  = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ss       <= 1'b1;
            sclk     <= cpol;
            mosi     <= 1'b0;
            dataout  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sclk     <= cpol;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    // The done cycle itself never accepts, guaranteeing one idle clk.
                    if (start && !done) begin
                        cpha_l <= cpha;
                        ss     <= 1'b0;
                        busy   <= 1'b1;
                        state  <= SETUP;
                        if (!cpha) begin
                            mosi  <= tx_bit(datain);
                            tx_sr <= tx_shift(datain);
                        end else begin
                            tx_sr <= datain;
                        end
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        state   <= XFER;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (leading) begin
                            if (cpha_l) begin
                                mosi  <= tx_bit(tx_sr);
                                tx_sr <= tx_shift(tx_sr);
                            end else begin
                                rx_sr <= rx_shift(rx_sr, miso);
                            end
                        end else begin
                            if (cpha_l) begin
                                rx_sr <= rx_shift(rx_sr, miso);
                            end else if (!last_edge) begin
                                mosi  <= tx_bit(tx_sr);
                                tx_sr <= tx_shift(tx_sr);
                            end
                        end
                        if (last_edge) begin
                            state <= FINISH;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        ss      <= 1'b1;
                        dataout <= rx_sr;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CLK_DIV=4 instance for mode/latency/abort cases,
// CLK_DIV=1 instance for back-to-back frames with start held high.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] datain;
    logic       cpol;
    logic       cpha;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic       ss;
    logic [7:0] dataout;
    logic       busy;
    logic       done;
    logic [1:0] statemon;
    logic       loop;
    logic       miso_val;

    logic       start_f;
    logic [7:0] datain_f;
    logic       sclk_f;
    logic       mosi_f;
    logic       ss_f;
    logic [7:0] dataout_f;
    logic       busy_f;
    logic       done_f;
    logic [1:0] statemon_f;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign miso = loop ? mosi : miso_val;

    spi_master #(.DATA_W(8), .CLK_DIV(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .datain(datain),
        .cpol(cpol), .cpha(cpha), .miso(miso), .sclk(sclk), .mosi(mosi),
        .ss(ss), .dataout(dataout), .busy(busy), .done(done), .statemon(statemon)
    );

    spi_master #(.DATA_W(8), .CLK_DIV(1)) u_fast (
        .clk(clk), .reset(reset), .start(start_f), .datain(datain_f),
        .cpol(1'b0), .cpha(1'b0), .miso(mosi_f), .sclk(sclk_f), .mosi(mosi_f),
        .ss(ss_f), .dataout(dataout_f), .busy(busy_f), .done(done_f), .statemon(statemon_f)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one frame on u_dut; optional disturbance (start/datain/mode flip) at cycle mid_cyc.
    task automatic run_frame(input logic [7:0] d, input logic p, input logic h,
                             input int mid_cyc, input logic [7:0] mid_d,
                             output int lat, output logic [7:0] seq,
                             output int edges, output int ss_hi, output int dones);
        logic prev_sclk;
        lat = 0; seq = 8'h00; edges = 0; ss_hi = 0; dones = 0;
        datain = d; cpol = p; cpha = h;
        @(posedge clk); #1;
        prev_sclk = sclk;
        start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (mid_cyc > 1 && c == mid_cyc) begin
                start = 1'b1; datain = mid_d; cpha = ~h; cpol = ~p;
            end
            if (mid_cyc > 1 && c == mid_cyc + 1) start = 1'b0;
            if (lat == 0 && !done && sclk != prev_sclk) begin
                edges++;
                if (sclk != p) seq = {seq[6:0], mosi};
            end
            prev_sclk = sclk;
            if (done) begin
                dones++;
                if (lat == 0) lat = c;
            end else if (lat == 0 && ss) begin
                ss_hi++;
            end
            if (lat != 0 && c >= lat + 4) break;
        end
        start = 1'b0;
        cpol = p; cpha = h;
    endtask

    initial begin
        int lat, edges, ss_hi, dones, dn, last_done, nfast;
        logic [7:0] seq;
        logic prev_ss;
        bit gap_seen;

        reset = 1'b0; start = 1'b0; datain = 8'h00; cpol = 1'b0; cpha = 1'b0;
        loop = 1'b1; miso_val = 1'b0; start_f = 1'b0; datain_f = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss", ss, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_state", statemon, 2'b00);
        chk("rst_dataout", dataout, 8'h00);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_fast_ss", ss_f, 1'b1);
        cpol = 1'b1;
        @(posedge clk); #1;
        chk("rst_sclk_cpol", sclk, 1'b1);
        reset = 1'b1;
        cpol = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_sclk_follow", sclk, 1'b0);

        // Mode 0 loopback D1
        run_frame(8'hD1, 1'b0, 1'b0, 0, 8'h00, lat, seq, edges, ss_hi, dones);
        chk("m0_latency", lat, 73);
        chk("m0_edges", edges, 16);
`ifdef SPI_MASTER_LSB_FIRST_EN
        chk("m0_mosi_seq", seq, 8'h8B);
`else
        chk("m0_mosi_seq", seq, 8'hD1);
`endif
        chk("m0_dataout", dataout, 8'hD1);
        chk("m0_ss_low", ss_hi, 0);
        chk("m0_dones", dones, 1);
        chk("m0_idle_state", statemon, 2'b00);

        // Mode 3, miso held high
        loop = 1'b0; miso_val = 1'b1; cpol = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("m3_sclk_idle", sclk, 1'b1);
        run_frame(8'hC6, 1'b1, 1'b1, 0, 8'h00, lat, seq, edges, ss_hi, dones);
        chk("m3_latency", lat, 73);
        chk("m3_edges", edges, 16);
        chk("m3_mosi_seq", seq, 8'hC6);
        chk("m3_dataout", dataout, 8'hFF);
        chk("m3_ss_low", ss_hi, 0);
        chk("m3_dones", dones, 1);
        chk("m3_sclk_end", sclk, 1'b1);

        // start re-asserted mid-frame with new datain and flipped mode
        loop = 1'b1; cpol = 1'b0;
        repeat (2) @(posedge clk);
        run_frame(8'hA5, 1'b0, 1'b0, 10, 8'h3C, lat, seq, edges, ss_hi, dones);
        chk("rest_dataout", dataout, 8'hA5);
        chk("rest_dones", dones, 1);
        chk("rest_latency", lat, 73);
        chk("rest_edges", edges, 16);

        // Reset in the middle of a frame
        repeat (2) @(posedge clk);
        datain = 8'h96; cpol = 1'b0; cpha = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        dn = 0;
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (done) dn++;
            if (c == 20) begin
                chk("abort_pre_busy", busy, 1'b1);
                reset = 1'b0;
            end
            if (c == 21) begin
                chk("abort_ss", ss, 1'b1);
                chk("abort_busy", busy, 1'b0);
                chk("abort_state", statemon, 2'b00);
                chk("abort_sclk", sclk, 1'b0);
                reset = 1'b1;
            end
        end
        chk("abort_no_done", dn, 0);
        run_frame(8'h3B, 1'b0, 1'b1, 0, 8'h00, lat, seq, edges, ss_hi, dones);
        chk("post_abort_dataout", dataout, 8'h3B);
        chk("post_abort_latency", lat, 73);

        // Bit-order check with a single set bit
        repeat (2) @(posedge clk);
        run_frame(8'h01, 1'b0, 1'b0, 0, 8'h00, lat, seq, edges, ss_hi, dones);
`ifdef SPI_MASTER_LSB_FIRST_EN
        chk("order_mosi_seq", seq, 8'h80);
`else
        chk("order_mosi_seq", seq, 8'h01);
`endif
        chk("order_dataout", dataout, 8'h01);

        // CLK_DIV=1, start held high: back-to-back frames
        @(posedge clk); #1;
        start_f = 1'b1;
        nfast = 0; last_done = 0; gap_seen = 1'b0; prev_ss = ss_f;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done_f) begin
                nfast++;
                chk("fast_dataout", dataout_f, 8'h5A);
                if (nfast == 1) chk("fast_first_done", c, 19);
                if (nfast == 2) chk("fast_period", c - last_done, 20);
                last_done = c;
            end
            if (!gap_seen && last_done != 0 && prev_ss && !ss_f) begin
                gap_seen = 1'b1;
                chk("fast_idle_gap", c - last_done, 2);
            end
            prev_ss = ss_f;
        end
        start_f = 1'b0;
        chk("fast_done_count", nfast, 3);
        chk("fast_gap_seen", gap_seen, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
